// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF neuron scheduler.
// Holds datapath width, reset threshold, index width helper and FSM states.
package lif_pkg;

  localparam int W              = 8;
  localparam int THRESH_DEFAULT = 40;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FLUSH
  } fsm_e;

endpackage

// File: rtl/lif_update.sv
// Shared LIF arithmetic: threshold test plus leak-and-integrate step.
// Ports: state/current/threshold in; spike flag and wrapped next_state out.
module lif_update #(
  parameter int W = lif_pkg::W
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] current,
  input  logic [W-1:0] threshold,
  output logic         spike,
  output logic [W-1:0] next_state
);

  logic [W-1:0] leak;

  assign spike      = (state >= threshold);
  assign leak       = spike ? '0 : (state >> 1);
  // Sum wraps at W bits; no saturation.
  assign next_state = current + leak;

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: sweeps N_NEURONS through one lif_update.
// Ports: clk/rst_n, step_start, current/threshold writes, spike stream, status.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS      = 8,
  parameter int W              = lif_pkg::W,
  parameter int THRESH_DEFAULT = lif_pkg::THRESH_DEFAULT,
  localparam int IW            = idx_w(N_NEURONS),
  localparam int CW            = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_start,
  input  logic          cur_we,
  input  logic [IW-1:0] cur_addr,
  input  logic [W-1:0]  cur_data,
  input  logic          thr_we,
  input  logic [W-1:0]  thr_data,
  output logic          spk_valid,
  input  logic          spk_ready,
  output logic [IW-1:0] spk_id,
  output logic          busy,
  output logic          step_done,
  output logic [CW-1:0] spk_count
);

  fsm_e          fsm_q;
  fsm_e          fsm_d;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  st_q  [N_NEURONS];
  logic [W-1:0]  cur_q [N_NEURONS];
  logic [W-1:0]  thr_q;
  logic [CW-1:0] cnt_q;

  logic          upd_spike;
  logic [W-1:0]  upd_next;
  logic          in_idle;
  logic          in_sweep;
  logic          out_free;
  logic          stall;
  logic          advance;
  logic          load;
  logic          last;

  lif_update #(.W(W)) u_update (
    .state      (st_q[idx_q]),
    .current    (cur_q[idx_q]),
    .threshold  (thr_q),
    .spike      (upd_spike),
    .next_state (upd_next)
  );

  assign in_idle  = (fsm_q == IDLE);
  assign in_sweep = (fsm_q == SWEEP);
  // Output register can take a new event this cycle.
  assign out_free = !spk_valid || spk_ready;
  // Only a spiking neuron needs the output register.
  assign stall    = in_sweep && upd_spike && !out_free;
  assign advance  = in_sweep && !stall;
  assign load     = advance && upd_spike;
  assign last     = (idx_q == IW'(N_NEURONS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (step_start)       fsm_d = SWEEP;
      SWEEP:   if (advance && last)  fsm_d = FLUSH;
      FLUSH:   if (out_free)         fsm_d = IDLE;
      default:                       fsm_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    step_done = 1'b0;
    unique case (1'b1)
      (fsm_q == SWEEP): busy = 1'b1;
      (fsm_q == FLUSH): begin
        busy      = 1'b1;
        step_done = out_free;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      thr_q     <= W'(THRESH_DEFAULT);
      cnt_q     <= '0;
      spk_count <= '0;
      spk_valid <= 1'b0;
      spk_id    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        st_q[i]  <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      // Host writes land before a same-cycle step_start is seen.
      if (in_idle) begin
        if (cur_we) cur_q[cur_addr] <= cur_data;
        if (thr_we) thr_q <= thr_data;
        if (step_start) begin
          idx_q <= '0;
          cnt_q <= '0;
        end
      end
      if (advance) begin
        st_q[idx_q]  <= upd_next;
        cur_q[idx_q] <= '0;
        idx_q        <= idx_q + IW'(1);
      end
      if (load) begin
        spk_valid <= 1'b1;
        spk_id    <= idx_q;
        cnt_q     <= cnt_q + CW'(1);
      end else if (spk_valid && spk_ready) begin
        spk_valid <= 1'b0;
      end
      if (step_done) spk_count <= cnt_q;
    end
  end

endmodule
